// File: rtl/tank_bullet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tank_bullet_ctrl
// Purpose  : Three-slot bullet engine for one tank: spawn, frame-rate motion,
//            edge bounce, lifetime expiry and opponent hit detection.
// Revision : 1.0 - initial release
// ============================================================================
module tank_bullet_ctrl #(
    parameter int SPEED    = 2,
    parameter int LIFETIME = 300,
    parameter int BSIZE    = 2,
    parameter int MUZZLE   = 12,
    parameter int XMIN     = 0,
    parameter int XMAX     = 639,
    parameter int YMIN     = 0,
    parameter int YMAX     = 479,
    parameter int COOLDOWN = 15
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic       enable,
    input  logic [9:0] TankX,
    input  logic [9:0] TankY,
    input  logic [7:0] sin,
    input  logic [7:0] cos,
    input  logic [9:0] OppX,
    input  logic [9:0] OppY,
    input  logic [9:0] Ball_size,
    input  logic       OppShot,
    output logic [9:0] Bullet0X,
    output logic [9:0] Bullet0Y,
    output logic [9:0] Bullet0S,
    output logic       is_bullet0_active,
    output logic [9:0] Bullet1X,
    output logic [9:0] Bullet1Y,
    output logic [9:0] Bullet1S,
    output logic       is_bullet1_active,
    output logic [9:0] Bullet2X,
    output logic [9:0] Bullet2Y,
    output logic [9:0] Bullet2S,
    output logic       is_bullet2_active,
    output logic       OppHit
);

    localparam int c_CDW = $clog2(COOLDOWN + 1);

    logic             r_frm_s1, r_frm_s2, r_frm_s3;
    logic             r_fire_s1, r_fire_s2, r_fire_s3;
    logic             w_tick, w_fire_rise;
    logic [13:0]      r_px   [3];
    logic [13:0]      r_py   [3];
    logic [11:0]      r_vx   [3];
    logic [11:0]      r_vy   [3];
    logic [8:0]       r_life [3];
    logic [2:0]       r_act;
    logic [c_CDW-1:0] r_cool;
    logic             r_fire_pend;
    logic             r_opp_hit;
    logic [9:0]       r_bx   [3];
    logic [9:0]       r_by   [3];
    logic [2:0]       r_act_q;

    logic [13:0]      w_nx   [3];
    logic [13:0]      w_ny   [3];
    logic [11:0]      w_nvx  [3];
    logic [11:0]      w_nvy  [3];
    logic [2:0]       w_hit;
    logic [10:0]      w_thr;
    logic [1:0]       w_slot;
    logic             w_any_free;
    logic [13:0]      w_spx, w_spy;
    logic [11:0]      w_svx, w_svy;

    assign w_tick      = r_frm_s2 & ~r_frm_s3;
    assign w_fire_rise = r_fire_s2 & ~r_fire_s3;
    assign w_thr       = {1'b0, Ball_size} + 11'(BSIZE);

    assign w_spx = {TankX, 4'b0} + {{6{cos[7]}}, cos} * 14'(MUZZLE);
    assign w_spy = {TankY, 4'b0} + {{6{sin[7]}}, sin} * 14'(MUZZLE);
    assign w_svx = {{4{cos[7]}}, cos} * 12'(SPEED);
    assign w_svy = {{4{sin[7]}}, sin} * 12'(SPEED);

    // Move one axis and reflect at the limits; the 15-bit sum keeps the sign
    // so that an underflow below zero is caught before the 14-bit wrap.
    function automatic logic [25:0] f_bounce(input logic [13:0] p, input logic [11:0] v,
                                             input int lo, input int hi);
        logic signed [14:0] s;
        s = $signed({1'b0, p}) + $signed({{3{v[11]}}, v});
        if (s < $signed(15'(lo * 16)))
            return {14'(lo * 16), -v};
        else if (s > $signed(15'(hi * 16 + 15)))
            return {14'(hi * 16), -v};
        else
            return {s[13:0], v};
    endfunction

    function automatic logic f_near(input logic [9:0] b, input logic [9:0] o,
                                    input logic [10:0] thr);
        logic [10:0] d;
        d = {1'b0, b} - {1'b0, o};
        if (d[10])
            d = -d;
        return d <= thr;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            {w_nx[i], w_nvx[i]} = f_bounce(r_px[i], r_vx[i], XMIN + BSIZE, XMAX - BSIZE);
            {w_ny[i], w_nvy[i]} = f_bounce(r_py[i], r_vy[i], YMIN + BSIZE, YMAX - BSIZE);
            w_hit[i] = r_act[i] & ~OppShot & f_near(w_nx[i][13:4], OppX, w_thr)
                                           & f_near(w_ny[i][13:4], OppY, w_thr);
        end
    end

    always_comb begin
        w_slot     = 2'd0;
        w_any_free = 1'b1;
        if (!r_act[0])
            w_slot = 2'd0;
        else if (!r_act[1])
            w_slot = 2'd1;
        else if (!r_act[2])
            w_slot = 2'd2;
        else
            w_any_free = 1'b0;
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            {r_frm_s1, r_frm_s2, r_frm_s3}    <= 3'b0;
            {r_fire_s1, r_fire_s2, r_fire_s3} <= 3'b0;
            for (int i = 0; i < 3; i++) begin
                r_px[i]   <= '0;
                r_py[i]   <= '0;
                r_vx[i]   <= '0;
                r_vy[i]   <= '0;
                r_life[i] <= '0;
                r_bx[i]   <= '0;
                r_by[i]   <= '0;
            end
            r_act       <= '0;
            r_act_q     <= '0;
            r_cool      <= '0;
            r_fire_pend <= 1'b0;
            r_opp_hit   <= 1'b0;
        end else begin
            {r_frm_s1, r_frm_s2, r_frm_s3}    <= {frame_clk, r_frm_s1, r_frm_s2};
            {r_fire_s1, r_fire_s2, r_fire_s3} <= {fire, r_fire_s1, r_fire_s2};
            r_opp_hit <= 1'b0;

            if (!enable)
                r_fire_pend <= 1'b0;
            else if (w_fire_rise)
                r_fire_pend <= 1'b1;

            if (w_tick && enable) begin
                for (int i = 0; i < 3; i++) begin
                    if (r_act[i]) begin
                        r_px[i]   <= w_nx[i];
                        r_py[i]   <= w_ny[i];
                        r_vx[i]   <= w_nvx[i];
                        r_vy[i]   <= w_nvy[i];
                        r_life[i] <= r_life[i] - 9'd1;
                        r_act[i]  <= ~w_hit[i] & (r_life[i] != 9'd1);
                    end
                end
                r_opp_hit <= |w_hit;
                if (r_cool != '0)
                    r_cool <= r_cool - 1'b1;
                // A pending shot waits out the cooldown; with no free slot it is dropped.
                if (r_fire_pend && r_cool == '0) begin
                    r_fire_pend <= 1'b0;
                    if (w_any_free) begin
                        r_act[w_slot]  <= 1'b1;
                        r_px[w_slot]   <= w_spx;
                        r_py[w_slot]   <= w_spy;
                        r_vx[w_slot]   <= w_svx;
                        r_vy[w_slot]   <= w_svy;
                        r_life[w_slot] <= 9'(LIFETIME);
                        r_cool         <= c_CDW'(COOLDOWN);
                    end
                end
            end

            for (int i = 0; i < 3; i++) begin
                r_bx[i] <= r_px[i][13:4];
                r_by[i] <= r_py[i][13:4];
            end
            r_act_q <= r_act;
        end
    end

    assign Bullet0X          = r_bx[0];
    assign Bullet0Y          = r_by[0];
    assign Bullet1X          = r_bx[1];
    assign Bullet1Y          = r_by[1];
    assign Bullet2X          = r_bx[2];
    assign Bullet2Y          = r_by[2];
    assign Bullet0S          = 10'(BSIZE);
    assign Bullet1S          = 10'(BSIZE);
    assign Bullet2S          = 10'(BSIZE);
    assign is_bullet0_active = r_act_q[0];
    assign is_bullet1_active = r_act_q[1];
    assign is_bullet2_active = r_act_q[2];
    assign OppHit            = r_opp_hit;

endmodule
`default_nettype wire

// File: tb/tb_tank_bullet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tank_bullet_ctrl
// Purpose  : Self-checking bench for tank_bullet_ctrl (vector table + queue).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tank_bullet_ctrl;

    logic       CLK = 1'b0;
    logic       Reset_n, frame_clk, fire, enable, OppShot;
    logic [9:0] TankX, TankY, OppX, OppY, Ball_size;
    logic [7:0] sin, cos;
    logic [9:0] Bullet0X, Bullet0Y, Bullet0S, Bullet1X, Bullet1Y, Bullet1S;
    logic [9:0] Bullet2X, Bullet2Y, Bullet2S;
    logic       is_bullet0_active, is_bullet1_active, is_bullet2_active, OppHit;

    int n_cmp = 0;
    int n_bad = 0;
    int hit_cnt = 0;

    always #5 CLK = ~CLK;
    always @(negedge CLK) if (OppHit) hit_cnt++;

    tank_bullet_ctrl dut (
        .CLK(CLK), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire), .enable(enable),
        .TankX(TankX), .TankY(TankY), .sin(sin), .cos(cos), .OppX(OppX), .OppY(OppY),
        .Ball_size(Ball_size), .OppShot(OppShot),
        .Bullet0X(Bullet0X), .Bullet0Y(Bullet0Y), .Bullet0S(Bullet0S), .is_bullet0_active(is_bullet0_active),
        .Bullet1X(Bullet1X), .Bullet1Y(Bullet1Y), .Bullet1S(Bullet1S), .is_bullet1_active(is_bullet1_active),
        .Bullet2X(Bullet2X), .Bullet2Y(Bullet2Y), .Bullet2S(Bullet2S), .is_bullet2_active(is_bullet2_active),
        .OppHit(OppHit)
    );

    typedef struct {
        int c, s, tx, ty, sx, sy, mx, my;
    } vec_t;

    typedef struct {
        string nm;
        int    slot, act, x, y;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    function automatic int get_act(input int k);
        case (k)
            0: return int'(is_bullet0_active);
            1: return int'(is_bullet1_active);
            default: return int'(is_bullet2_active);
        endcase
    endfunction

    function automatic int get_x(input int k);
        case (k)
            0: return int'(Bullet0X);
            1: return int'(Bullet1X);
            default: return int'(Bullet2X);
        endcase
    endfunction

    function automatic int get_y(input int k);
        case (k)
            0: return int'(Bullet0Y);
            1: return int'(Bullet1Y);
            default: return int'(Bullet2Y);
        endcase
    endfunction

    task automatic push(input string nm, input int slot, input int act, input int x, input int y);
        exp_t e;
        e.nm = nm; e.slot = slot; e.act = act; e.x = x; e.y = y;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s slot%0d act", e.nm, e.slot), get_act(e.slot), e.act);
            if (e.act != 0) begin
                chk($sformatf("%s slot%0d x", e.nm, e.slot), get_x(e.slot), e.x);
                chk($sformatf("%s slot%0d y", e.nm, e.slot), get_y(e.slot), e.y);
            end
        end
    endtask

    task automatic do_reset();
        Reset_n = 1'b0; frame_clk = 1'b0; fire = 1'b0;
        repeat (3) @(negedge CLK);
        Reset_n = 1'b1;
        @(negedge CLK);
    endtask

    // Frame edge: tick lands on the 3rd CLK edge, outputs settle on the 4th.
    task automatic do_frame();
        @(negedge CLK) frame_clk = 1'b1;
        repeat (4) @(negedge CLK);
        frame_clk = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic do_fire();
        @(negedge CLK) fire = 1'b1;
        repeat (3) @(negedge CLK);
        fire = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic setup(input int c, input int s, input int tx, input int ty,
                         input int ox, input int oy);
        cos = 8'(c); sin = 8'(s); TankX = 10'(tx); TankY = 10'(ty);
        OppX = 10'(ox); OppY = 10'(oy); Ball_size = 10'd10; OppShot = 1'b0; enable = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        int   h0;
        vt[0] = '{16,   0, 100, 200, 112, 200, 114, 200};
        vt[1] = '{0,   16, 300, 100, 300, 112, 300, 114};
        vt[2] = '{-16,  0, 300, 240, 288, 240, 286, 240};
        vt[3] = '{0,  -16, 320, 300, 320, 288, 320, 286};
        vt[4] = '{8,    8, 200, 200, 206, 206, 207, 207};
        vt[5] = '{-11, 13, 400, 150, 391, 159, 390, 161};

        setup(16, 0, 100, 200, 600, 400);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset act%0d", k), get_act(k), 0);
            chk($sformatf("reset x%0d", k), get_x(k), 0);
            chk($sformatf("reset y%0d", k), get_y(k), 0);
        end
        chk("reset size", int'(Bullet1S), 2);
        chk("reset opphit", int'(OppHit), 0);

        // Spawn at the muzzle, then one move step, for several headings.
        foreach (vt[v]) begin
            setup(vt[v].c, vt[v].s, vt[v].tx, vt[v].ty, 600, 400);
            do_reset();
            do_fire();
            push($sformatf("vec%0d spawn", v), 0, 1, vt[v].sx, vt[v].sy);
            push($sformatf("vec%0d spawn", v), 1, 0, 0, 0);
            do_frame();
            drain();
            push($sformatf("vec%0d move", v), 0, 1, vt[v].mx, vt[v].my);
            do_frame();
            drain();
        end

        // Slot allocation order with cooldown spacing; fourth shot dropped.
        setup(16, 0, 100, 200, 600, 400);
        do_reset();
        for (int shot = 0; shot < 4; shot++) begin
            do_fire();
            for (int k = 0; k < 3; k++) begin
                if (k < shot || (k == shot && shot < 3))
                    push($sformatf("alloc%0d", shot), k, 1, 112 + 2 * 16 * (shot - k), 200);
                else
                    push($sformatf("alloc%0d", shot), k, 0, 0, 0);
            end
            do_frame();
            drain();
            if (shot < 3) repeat (15) do_frame();
        end
        push("dropped next", 0, 1, 210, 200);
        push("dropped next", 1, 1, 178, 200);
        push("dropped next", 2, 1, 146, 200);
        do_frame();
        drain();

        // Right-edge bounce.
        setup(16, 0, 624, 240, 100, 400);
        do_reset();
        do_fire();
        push("xbounce spawn", 0, 1, 636, 240); do_frame(); drain();
        push("xbounce clamp", 0, 1, 637, 240); do_frame(); drain();
        push("xbounce back",  0, 1, 635, 240); do_frame(); drain();

        // Corner bounce: both axes reflect on the same tick.
        setup(16, -16, 624, 15, 100, 400);
        do_reset();
        do_fire();
        push("corner spawn", 0, 1, 636, 3); do_frame(); drain();
        push("corner clamp", 0, 1, 637, 2); do_frame(); drain();
        push("corner back",  0, 1, 635, 4); do_frame(); drain();
        push("corner back2", 0, 1, 633, 6); do_frame(); drain();

        // Hit on the opponent at x=150: bullet reaches x=138 on move 13.
        setup(16, 0, 100, 200, 150, 200);
        do_reset();
        do_fire();
        do_frame();
        h0 = hit_cnt;
        repeat (12) do_frame();
        push("hit pre", 0, 1, 136, 200);
        drain();
        chk("hit pre opphit count", hit_cnt - h0, 0);
        do_frame();
        push("hit post", 0, 0, 0, 0);
        drain();
        chk("hit opphit count", hit_cnt - h0, 1);
        repeat (2) do_frame();
        chk("hit opphit after", hit_cnt - h0, 1);

        // OppShot set: bullet passes through.
        setup(16, 0, 100, 200, 150, 200);
        OppShot = 1'b1;
        do_reset();
        do_fire();
        do_frame();
        h0 = hit_cnt;
        repeat (20) do_frame();
        push("oppshot pass", 0, 1, 152, 200);
        drain();
        chk("oppshot opphit count", hit_cnt - h0, 0);

        // Enable low freezes motion.
        setup(16, 0, 100, 200, 600, 400);
        do_reset();
        do_fire();
        do_frame();
        enable = 1'b0;
        push("frozen", 0, 1, 112, 200); do_frame(); drain();
        enable = 1'b1;
        push("resumed", 0, 1, 114, 200); do_frame(); drain();

        // Lifetime expiry of a stationary bullet.
        setup(0, 0, 320, 240, 600, 400);
        do_reset();
        do_fire();
        do_frame();
        repeat (299) do_frame();
        push("life 299", 0, 1, 320, 240); drain();
        do_frame();
        push("life 300", 0, 0, 0, 0); drain();

        // Asynchronous reset mid-flight.
        setup(16, 0, 100, 200, 600, 400);
        do_reset();
        do_fire();
        do_frame();
        push("pre async", 0, 1, 112, 200); drain();
        @(posedge CLK);
        #2 Reset_n = 1'b0;
        #1 chk("async act0", get_act(0), 0);
        @(negedge CLK) Reset_n = 1'b1;
        repeat (3) do_frame();
        push("after async", 0, 0, 0, 0); drain();
        do_fire();
        push("refire", 0, 1, 112, 200); do_frame(); drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tank_bullet_ctrl.md
Name: tank_bullet_ctrl

Overview:
- Per-tank bullet engine: owns up to 3 bullet slots for one tank.
- Spawns bullets on fire, advances them once per video frame along the tank heading, bounces them off the screen edges, retires them on lifetime expiry or on hitting the opposing tank.
- Directly upstream of the colour mapper: drives its BulletNX/BulletNY/BulletNS/is_bulletN_active inputs and feeds the opponent's shot flag to game control.
- Instantiated twice (one per tank).

Parameters:
- SPEED, 2, pixels per frame at unit heading.
- LIFETIME, 300, frames a bullet lives before retiring.
- BSIZE, 2, bullet half-size in pixels, driven on BulletkS.
- MUZZLE, 12, spawn offset from tank centre along heading, pixels.
- XMIN/XMAX, 0/639, horizontal bounce limits.
- YMIN/YMAX, 0/479, vertical bounce limits.
- COOLDOWN, 15, minimum frames between spawns.

Ports:
- CLK in 1: system clock.
- Reset_n in 1: asynchronous, active-low reset.
- frame_clk in 1: VGA vsync, asynchronous to CLK.
- fire in 1: fire button, level, asynchronous.
- enable in 1: game running; 0 freezes all motion and blocks spawning.
- TankX, TankY in 10 each: own tank centre.
- sin, cos in 8 each: own heading, signed two's complement, 16 = 1.0.
- OppX, OppY in 10 each: opponent tank centre.
- Ball_size in 10: tank half-size.
- OppShot in 1: opponent already destroyed.
- BulletkX, BulletkY out 10 each (k=0..2): bullet centre, integer pixels.
- BulletkS out 10 (k=0..2): constant BSIZE.
- is_bulletk_active out 1 (k=0..2): slot k live.
- OppHit out 1: one-CLK pulse when any bullet hits the opponent.

Behaviour:
Reset (Reset_n low, async):
- All slots inactive; positions 0; velocities 0.
- Lifetime and cooldown counters 0; fire_pending 0; OppHit 0.
- Synchronizer flops cleared.
- Reset mid-frame discards all live bullets; no partial update is observable.

Synchronization:
- frame_clk and fire each pass a 2-flop synchronizer, then rising-edge detect.
- A fire rising edge sets fire_pending. It stays set until consumed at a frame tick; further edges while pending are ignored.

Slot state:
- Position px, py: 14-bit unsigned, 10.4 fixed point.
- Velocity vx, vy: signed 12-bit, 4 fractional bits. At spawn vx = cos*SPEED, vy = sin*SPEED, both sign-extended.
- Lifetime counter: 9 bits.
- BulletkX = px[13:4], BulletkY = py[13:4], registered.

Frame tick (one CLK cycle, when enable=1). All slots are processed in parallel; each active slot applies, in order:
1. Move: px += vx, py += vy, wrapping mod 2^14 internally.
2. Bounce:
   - If the new x integer part is < XMIN+BSIZE or > XMAX-BSIZE (a negative result detected via the sign of the wide sum): clamp x to the violated limit and negate vx.
   - Same rule for y with YMIN/YMAX and vy.
   - A corner bounce negates both velocities in the same tick.
3. Hit: if |BX-OppX| <= Ball_size+BSIZE and |BY-OppY| <= Ball_size+BSIZE and OppShot=0:
   - Slot goes inactive.
   - OppHit pulses high for exactly the one CLK following the tick.
   - Multiple simultaneous hits produce a single pulse.
4. Life: counter decrements; on reaching 0 the slot goes inactive. A hit and an expiry in the same tick count as a hit.

Spawn (same tick, after slot update):
- Condition: fire_pending=1 and cooldown=0.
- Target: lowest-index slot that was inactive before this tick. Slots freed in this tick are not eligible.
- New bullet: px = (TankX<<4) + cos*MUZZLE, py likewise with sin. Lifetime = LIFETIME; cooldown = COOLDOWN.
- The new bullet is not moved in its spawn tick.
- If no slot is free: fire_pending is cleared and the shot is dropped.
- Cooldown decrements each tick while nonzero.

Enable and timing:
- enable=0: ticks do nothing; fire_pending is cleared; state is held.
- Output latency: position outputs update on the CLK edge 1 cycle after the tick cycle. The tick cycle itself is 3 CLK after the frame_clk rising edge (synchronizer plus edge detect).

Test Plan:
1. Reset, enable=1, cos=16, sin=0, TankX=100, TankY=200, fire pulse, one frame tick → Bullet0 active at (112,200); next tick (114,200).
2. Three fires spaced ≥ COOLDOWN frames, then a fourth with all slots live → slots 0,1,2 active in order; fourth shot dropped, no slot change.
3. Bullet at x=636, vx=+2 → next tick x clamped to 637 (XMAX-BSIZE), vx=-2; following tick x=635.
4. Bullet path crossing opponent at OppX=150, Ball_size=10 → slot inactive and single OppHit pulse on the tick where |BX-150| ≤ 12; with OppShot=1 there is no hit and the bullet passes through.
5. Let a bullet live untouched → is_bullet0_active falls exactly LIFETIME ticks after spawn.
6. Assert Reset_n low mid-flight between CLK edges → all active flags drop immediately (async) and remain 0 until a new fire.
